lm_sm_sequencer: RTL and testbench
==================================

// Module: lm_sm_sequencer
// PURPOSE
//  Decode-stage micro-sequencer for load-multiple (LM) and store-multiple (SM).
//  Expands one LM/SM into one micro-op per set bit of its 8-bit register list, lowest register first.
//  Each micro-op carries a register index and a memory address (base + k).
//  Sits directly upstream of reg_read. uop_reg drives readAdd2 for SM; it is carried down the pipe to writeAdd for LM.
//  Freezes fetch/decode while the expansion runs.
// PARAMETERS
//  DATA_W     16  data/address width
//  REG_ADDR_W 3   register index width
//  LIST_W     8   register-list width (= 2**REG_ADDR_W)
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  reset        in   1       synchronous, active-low reset
//  start        in   1       decode presents a valid LM/SM this cycle
//  is_store     in   1       1 = SM, 0 = LM (sampled with start)
//  reg_list     in   LIST_W  register list; bit i selects Ri (sampled with start)
//  base_value   in   DATA_W  base address, RA value (sampled with start)
//  stall_in     in   1       downstream cannot take a micro-op this cycle
//  flush        in   1       squash sequence (branch/R7 redirect from later stage)
//  ready        out  1       may accept start this cycle
//  stall_fetch  out  1       hold fetch and decode registers
//  uop_valid    out  1       micro-op outputs valid
//  uop_reg      out  REG_ADDR_W  register index of micro-op
//  uop_addr     out  DATA_W  memory address of micro-op
//  uop_is_store out  1       micro-op is a store
//  uop_last     out  1       final micro-op of the sequence
// BEHAVIOUR
//  - Reset (reset==0 at edge):
//    state=IDLE; rem=0; offset=0; uop_valid=0; uop_reg=0; uop_addr=0;
//    uop_is_store=0; uop_last=0. Wins over every other input.
//  - FSM: IDLE, RUN. Registered state; rem = remaining list; offset = DATA_W counter; base/is_store latched.
//  - slot_free = ~uop_valid | ~stall_in. Output regs load only when slot_free; otherwise hold every bit stable.
//  - ready = (state==IDLE) & slot_free (combinational). stall_fetch = (state==RUN) (combinational).
//  - Accept = start & ready & |reg_list. Start while ~ready is a protocol violation: ignored, no state change.
//  - On accept, outputs load the first micro-op and are visible the next cycle (latency 1):
//    reg = lowest set bit; addr = base_value; last = (exactly one bit set).
//    rem = reg_list minus that bit; offset = 1; state = RUN if rem != 0, else stays IDLE.
//  - RUN, edge with slot_free:
//    load reg = lowest bit of rem; addr = base + offset (mod 2**DATA_W, wraps silently); last = (rem has one bit).
//    Clear that bit; offset += 1. When the loaded op is last, state goes to IDLE.
//  - IDLE, slot_free, no accept: uop_valid = 0 (bubble).
//  - start with reg_list==0: LM/SM is a no-op. No micro-op, state unchanged, ready behaves as normal.
//  - uop_is_store = latched is_store for every micro-op of a sequence.
//  - uop_reg==7 is emitted like any other register. PC-write handling belongs downstream.
//  - flush==1 at edge (reset inactive): state=IDLE, rem=0, uop_valid=0, uop_last=0. Overrides accept and stall_in.
//  - Reset or flush mid-sequence: no partial micro-op is emitted afterwards.
// STRUCTURE
//  - Shared package/header: DATA_W, REG_ADDR_W, LIST_W, R7 index, LM/SM opcodes, FSM state encodings.
//  - Sub-module pri_enc8: combinational lowest-set-bit encoder. in[7:0] -> idx[2:0], any, one_hot_only.
//    Instantiated once on the mux of reg_list (IDLE) / rem (RUN).
//  - Remainder is one always block: FSM, counters, output register.
// TESTING
//  1 Reset: hold reset=0 two cycles with start=1 -> all outputs 0, ready=1, stall_fetch=0.
//  2 LM, list 8'b1010_0101, base 16'h0100, stall_in=0:
//    cycles 1..4 -> uop_reg 0,2,5,7; addr 0100..0103; last only on reg7;
//    stall_fetch=1 in cycles 1..3; ready=1 again in cycle 4.
//  3 SM, list 8'h0F, stall_in=1 for 2 cycles while reg1 is presented
//    -> reg1/addr base+1 held 3 cycles unchanged; then reg2, reg3; uop_is_store=1 throughout.
//  4 LM, list 8'hFF, base 16'hFFFE -> addrs FFFE, FFFF, 0000..0005; 8 uops; last on reg7.
//  5 SM, list 8'b1000_0000 -> single uop reg7, last=1, stall_fetch never 1;
//    list 8'h00 -> no uop_valid, state stays IDLE.
//  6 Mid-sequence, list 8'hFF: flush at 3rd uop -> uop_valid=0 next cycle, ready=1, no further uops;
//    repeat with reset=0 -> full reset values.

Source files
------------

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared constants and FSM encoding for the LM/SM micro-sequencer.
package lm_sm_sequencer_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int LIST_W     = 8;

  localparam logic [REG_ADDR_W-1:0] R7    = 3'd7;
  localparam logic [3:0]            OP_LM = 4'b0110;
  localparam logic [3:0]            OP_SM = 4'b0111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seqState_t;
endpackage

// File: rtl/lm_sm_sequencer_pri_enc8.sv
// Lowest-set-bit encoder over an 8-bit register list.
module pri_enc8 (
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any,
  output logic       one_hot_only
);
  always_comb begin
    idx = 3'd0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = 7; i >= 0; i--)
      if (in[i]) idx = i[2:0];
    any          = |in;
    one_hot_only = any && ((in & (in - 8'd1)) == 8'd0);
  end
endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM into one micro-op per set register-list bit, lowest first.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [LIST_W-1:0]     reg_list,
  input  logic [DATA_W-1:0]     base_value,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  ready,
  output logic                  stall_fetch,
  output logic                  uop_valid,
  output logic [REG_ADDR_W-1:0] uop_reg,
  output logic [DATA_W-1:0]     uop_addr,
  output logic                  uop_is_store,
  output logic                  uop_last
);
  seqState_t             state, stateNxt;
  logic [LIST_W-1:0]     rem, encIn, lowMask;
  logic [DATA_W-1:0]     offset, baseQ;
  logic                  storeQ;
  logic [REG_ADDR_W-1:0] encIdx;
  logic                  encAny, encOne;
  logic                  slotFree, accept;

  assign slotFree = ~uop_valid | ~stall_in;
  assign encIn    = (state == S_IDLE) ? reg_list : rem;
  assign lowMask  = LIST_W'(1) << encIdx;
  assign accept   = start & ready & encAny;

  pri_enc8 uEnc (
    .in           (encIn),
    .idx          (encIdx),
    .any          (encAny),
    .one_hot_only (encOne)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    if (flush) stateNxt = S_IDLE;
    else if (slotFree) begin
      case (state)
        S_IDLE:  if (accept && !encOne) stateNxt = S_RUN;
        S_RUN:   if (encOne) stateNxt = S_IDLE;
        default: stateNxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready       = (state == S_IDLE) & slotFree;
    stall_fetch = (state == S_RUN);
  end

  // Output register only advances when the downstream slot is free; otherwise every bit holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem          <= '0;
      offset       <= '0;
      baseQ        <= '0;
      storeQ       <= 1'b0;
      uop_valid    <= 1'b0;
      uop_reg      <= '0;
      uop_addr     <= '0;
      uop_is_store <= 1'b0;
      uop_last     <= 1'b0;
    end else if (flush) begin
      rem       <= '0;
      uop_valid <= 1'b0;
      uop_last  <= 1'b0;
    end else if (slotFree) begin
      if (state == S_IDLE) begin
        if (accept) begin
          rem          <= reg_list & ~lowMask;
          offset       <= DATA_W'(1);
          baseQ        <= base_value;
          storeQ       <= is_store;
          uop_valid    <= 1'b1;
          uop_reg      <= encIdx;
          uop_addr     <= base_value;
          uop_is_store <= is_store;
          uop_last     <= encOne;
        end else begin
          uop_valid <= 1'b0;
        end
      end else begin
        rem          <= rem & ~lowMask;
        offset       <= offset + DATA_W'(1);
        uop_valid    <= 1'b1;
        uop_reg      <= encIdx;
        uop_addr     <= baseQ + offset;
        uop_is_store <= storeQ;
        uop_last     <= encOne;
      end
    end
  end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: expected micro-ops queued at start, popped on transfer.
module tb_lm_sm_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, is_store, stall_in, flush;
  logic [7:0]  reg_list;
  logic [15:0] base_value;
  logic        ready, stall_fetch, uop_valid, uop_is_store, uop_last;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;

  int nChecks = 0;
  int nFail   = 0;
  logic [20:0] sb[$];

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .reg_list(reg_list), .base_value(base_value), .stall_in(stall_in),
    .flush(flush), .ready(ready), .stall_fetch(stall_fetch),
    .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_addr(uop_addr),
    .uop_is_store(uop_is_store), .uop_last(uop_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer happens when valid and not stalled; flushed ops are squashed.
  always @(negedge clk) begin
    if (reset === 1'b1 && flush === 1'b0 && uop_valid === 1'b1 && stall_in === 1'b0) begin
      if (sb.size() == 0) chk("unexpected_uop", {11'd0, uop_reg, uop_addr, uop_is_store, uop_last}, 32'hDEAD);
      else chk("uop", {11'd0, uop_reg, uop_addr, uop_is_store, uop_last}, {11'd0, sb.pop_front()});
    end
  end

  task automatic pushExp(input logic st, input logic [7:0] list, input logic [15:0] base, input int maxN);
    int total, k;
    total = 0;
    for (int i = 0; i < 8; i++) if (list[i]) total++;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (list[i] && k < maxN) begin
        logic [2:0] r;
        logic [15:0] a;
        r = i[2:0];
        a = base + 16'(k);
        sb.push_back({r, a, st, (k == total - 1) ? 1'b1 : 1'b0});
      end
      if (list[i]) k++;
    end
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  // Leaves the bench 1ns into the cycle where the first micro-op is visible.
  task automatic startSeq(input logic st, input logic [7:0] list, input logic [15:0] base, input int maxN);
    @(posedge clk); #1;
    waitReady();
    start = 1'b1; is_store = st; reg_list = list; base_value = base;
    pushExp(st, list, base, maxN);
    @(posedge clk); #1;
    start = 1'b0; reg_list = 8'h00;
  endtask

  task automatic drain(output bit sawStall);
    bit done;
    done = 0; sawStall = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk); #1;
      if (stall_fetch) sawStall = 1;
      if (sb.size() == 0 && !stall_fetch && !uop_valid) done = 1;
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_valid"}, {31'd0, uop_valid}, 32'd0);
    chk({tag, "_reg"},   {29'd0, uop_reg}, 32'd0);
    chk({tag, "_addr"},  {16'd0, uop_addr}, 32'd0);
    chk({tag, "_store"}, {31'd0, uop_is_store}, 32'd0);
    chk({tag, "_last"},  {31'd0, uop_last}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_sf"},    {31'd0, stall_fetch}, 32'd0);
  endtask

  initial begin
    bit sawStall;
    logic [1:0] sfExp [4];
    logic [1:0] rdExp [4];
    reset = 1'b0; start = 1'b1; is_store = 1'b1; reg_list = 8'hFF;
    base_value = 16'h1234; stall_in = 1'b0; flush = 1'b0;

    // 1: reset dominates start
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkResetVals("rst");
    #1 reset = 1'b1; start = 1'b0; reg_list = 8'h00;

    // 2: LM 1010_0101 at base 0x0100
    sfExp = '{2'd1, 2'd1, 2'd1, 2'd0};
    rdExp = '{2'd0, 2'd0, 2'd0, 2'd1};
    startSeq(1'b0, 8'b1010_0101, 16'h0100, 8);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("lm_sf_c%0d", c + 1), {31'd0, stall_fetch}, {31'd0, sfExp[c][0]});
      chk($sformatf("lm_rdy_c%0d", c + 1), {31'd0, ready}, {31'd0, rdExp[c][0]});
    end
    drain(sawStall);

    // 3: SM 0x0F with stall while reg1 is presented
    startSeq(1'b1, 8'h0F, 16'h0040, 8);
    @(posedge clk); #1 stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold_reg_%0d", c), {29'd0, uop_reg}, 32'd1);
      chk($sformatf("hold_addr_%0d", c), {16'd0, uop_addr}, 32'h0041);
      chk($sformatf("hold_st_%0d", c), {31'd0, uop_is_store}, 32'd1);
      @(posedge clk); #1;
      if (c == 1) stall_in = 1'b0;
    end
    drain(sawStall);

    // 4: full list with address wrap
    startSeq(1'b0, 8'hFF, 16'hFFFE, 8);
    drain(sawStall);

    // 5: single-bit SM never freezes fetch; empty list is a no-op
    startSeq(1'b1, 8'b1000_0000, 16'h0300, 8);
    drain(sawStall);
    chk("single_sf", {31'd0, sawStall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b1; reg_list = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("empty_valid_%0d", c), {31'd0, uop_valid}, 32'd0);
      chk($sformatf("empty_sf_%0d", c), {31'd0, stall_fetch}, 32'd0);
      chk($sformatf("empty_rdy_%0d", c), {31'd0, ready}, 32'd1);
    end
    @(posedge clk); #1 start = 1'b0;

    // 6a: flush on the third micro-op
    startSeq(1'b0, 8'hFF, 16'h0200, 2);
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, uop_valid}, 32'd0);
    chk("flush_ready", {31'd0, ready}, 32'd1);
    chk("flush_sf", {31'd0, stall_fetch}, 32'd0);
    sawStall = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (uop_valid) sawStall = 1;
    end
    chk("flush_no_more", {31'd0, sawStall}, 32'd0);
    chk("flush_sb_empty", sb.size(), 32'd0);

    // 6b: reset on the third micro-op
    startSeq(1'b1, 8'hFF, 16'h0500, 2);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chkResetVals("mrst");
    sawStall = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (uop_valid) sawStall = 1;
    end
    chk("mrst_no_more", {31'd0, sawStall}, 32'd0);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFail);
    $finish;
  end
endmodule
